// File: rtl/vm2002_pkg.sv
// Shared types and helpers for the vm2002 change-return engine.
package vm2002_pkg;

   typedef enum logic [2:0] {
      NONE    = 3'd0,
      NICKEL  = 3'd1,
      DIME    = 3'd2,
      QUARTER = 3'd3,
      DOLLAR  = 3'd4
   } coin_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SELECT,
      S_ISSUE,
      S_DONE
   } change_state_t;

   localparam int unsigned N_DENOM = 4;

   function automatic logic [15:0] coin_value(input coin_t c);
      case (c)
         NICKEL:  return 16'd5;
         DIME:    return 16'd10;
         QUARTER: return 16'd25;
         DOLLAR:  return 16'd100;
         default: return 16'd0;
      endcase
   endfunction

   // Inventory slot 0..3 maps to NICKEL..DOLLAR, matching the empty bit order.
   function automatic coin_t denom_coin(input int unsigned idx);
      return coin_t'(3'(idx + 1));
   endfunction

endpackage

// File: rtl/vm2002_change_if.sv
// Refund, hopper and supplier-load signals of the change-return engine.
interface vm2002_change_if #(parameter int unsigned INV_W = 8);
   import vm2002_pkg::*;

   logic             refund_valid;
   logic [15:0]      refund_amt;
   logic             refund_ready;
   logic             coin_valid;
   coin_t            coin_out;
   logic             coin_ack;
   logic             load_valid;
   coin_t            load_coin;
   logic [INV_W-1:0] load_count;
   logic             done;
   logic [15:0]      short_amt;
   logic [3:0]       empty;

   modport master (
      output refund_valid, refund_amt, coin_ack, load_valid, load_coin, load_count,
      input  refund_ready, coin_valid, coin_out, done, short_amt, empty
   );

   modport slave (
      input  refund_valid, refund_amt, coin_ack, load_valid, load_coin, load_count,
      output refund_ready, coin_valid, coin_out, done, short_amt, empty
   );

endinterface

// File: rtl/vm2002_coin_inv.sv
// Saturating per-denomination coin counter with load increment, single-coin
// decrement and a registered empty flag.
module vm2002_coin_inv #(
   parameter int unsigned INV_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_inc,
   input  logic [INV_W-1:0] i_inc_cnt,
   input  logic             i_dec,
   output logic             o_empty
);

   localparam logic [INV_W:0] MAX = {1'b0, {INV_W{1'b1}}};

   logic [INV_W-1:0] r_count;
   logic             r_empty;
   logic [INV_W:0]   w_sum;
   logic [INV_W:0]   w_adj;
   logic [INV_W-1:0] w_next;

   // Add before subtracting so a same-cycle load and dispense saturate once.
   always_comb begin
      w_sum  = {1'b0, r_count} + (i_inc ? {1'b0, i_inc_cnt} : '0);
      w_adj  = (i_dec && (w_sum != '0)) ? (w_sum - (INV_W+1)'(1)) : w_sum;
      w_next = (w_adj > MAX) ? MAX[INV_W-1:0] : w_adj[INV_W-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
         r_empty <= 1'b1;
      end else begin
         r_count <= w_next;
         r_empty <= (w_next == '0);
      end
   end

   assign o_empty = r_empty;

endmodule

// File: rtl/vm2002_change.sv
// Change-return engine: greedy largest-first coin payout over a valid/ack
// hopper handshake, with shortfall reporting and live inventory loading.
module vm2002_change
   import vm2002_pkg::*;
#(
   parameter int unsigned INV_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   vm2002_change_if.slave        bus
);

   change_state_t        r_state, w_state_nxt;
   logic [15:0]          r_remaining, w_remaining_nxt;
   logic [15:0]          r_short, w_short_nxt;
   coin_t                r_coin, w_coin_nxt;
   coin_t                w_sel;
   logic [N_DENOM-1:0]   w_empty;
   logic [N_DENOM-1:0]   w_inc;
   logic [N_DENOM-1:0]   w_dec;

   for (genvar g = 0; g < N_DENOM; g++) begin : g_inv
      vm2002_coin_inv #(.INV_W(INV_W)) u_inv (
         .clk       (clk),
         .rst       (rst),
         .i_inc     (w_inc[g]),
         .i_inc_cnt (bus.load_count),
         .i_dec     (w_dec[g]),
         .o_empty   (w_empty[g])
      );
   end

   always_comb begin
      w_inc = '0;
      w_dec = '0;
      for (int unsigned i = 0; i < N_DENOM; i++) begin
         w_inc[i] = bus.load_valid && (bus.load_coin == denom_coin(i));
         w_dec[i] = (r_state == S_ISSUE) && bus.coin_ack && (r_coin == denom_coin(i));
      end
   end

   // Ascending scan: the last qualifying denomination is the largest.
   always_comb begin
      w_sel = NONE;
      for (int unsigned i = 0; i < N_DENOM; i++) begin
         if (!w_empty[i] && (coin_value(denom_coin(i)) <= r_remaining))
            w_sel = denom_coin(i);
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_remaining_nxt = r_remaining;
      w_short_nxt     = r_short;
      w_coin_nxt      = r_coin;
      case (r_state)
         S_IDLE: begin
            if (bus.refund_valid) begin
               w_state_nxt     = S_SELECT;
               w_remaining_nxt = bus.refund_amt;
               w_short_nxt     = '0;
            end
         end
         S_SELECT: begin
            if (w_sel != NONE) begin
               w_coin_nxt  = w_sel;
               w_state_nxt = S_ISSUE;
            end else begin
               w_short_nxt = r_remaining;
               w_state_nxt = S_DONE;
            end
         end
         S_ISSUE: begin
            if (bus.coin_ack) begin
               w_remaining_nxt = r_remaining - coin_value(r_coin);
               w_state_nxt     = S_SELECT;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_remaining <= '0;
         r_short     <= '0;
         r_coin      <= NONE;
      end else begin
         r_state     <= w_state_nxt;
         r_remaining <= w_remaining_nxt;
         r_short     <= w_short_nxt;
         r_coin      <= w_coin_nxt;
      end
   end

   assign bus.refund_ready = (r_state == S_IDLE);
   assign bus.coin_valid   = (r_state == S_ISSUE);
   assign bus.coin_out     = (r_state == S_ISSUE) ? r_coin : NONE;
   assign bus.done         = (r_state == S_DONE);
   assign bus.short_amt    = r_short;
   assign bus.empty        = w_empty;

endmodule

// File: tb/tb_vm2002_change.sv
// Bench for vm2002_change: directed scenarios plus randomized refunds checked
// against a greedy payout model of the coin inventory.
module tb_vm2002_change;
   import vm2002_pkg::*;

   localparam int unsigned INV_W = 8;

   logic clk = 1'b0;
   logic rst;

   vm2002_change_if #(.INV_W(INV_W)) bus ();

   vm2002_change #(.INV_W(INV_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int inv_m[4];
   int val[4] = '{5, 10, 25, 100};
   int exp_q[$];
   int exp_short;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] model_empty();
      logic [3:0] e;
      for (int i = 0; i < 4; i++) e[i] = (inv_m[i] == 0);
      return e;
   endfunction

   task automatic do_load(input int idx, input int cnt);
      bus.load_valid = 1'b1;
      bus.load_coin  = coin_t'(3'(idx + 1));
      bus.load_count = INV_W'(cnt);
      tick;
      bus.load_valid = 1'b0;
      bus.load_coin  = NONE;
      inv_m[idx] = (inv_m[idx] + cnt > 255) ? 255 : inv_m[idx] + cnt;
   endtask

   // Greedy payout computed directly on the model inventory.
   task automatic model_refund(input int amt);
      int rem;
      int pick;
      exp_q.delete();
      rem = amt;
      forever begin
         pick = -1;
         for (int i = 0; i < 4; i++)
            if (inv_m[i] > 0 && val[i] <= rem) pick = i;
         if (pick < 0) break;
         exp_q.push_back(pick + 1);
         inv_m[pick]--;
         rem -= val[pick];
      end
      exp_short = rem;
   endtask

   task automatic run_refund(input int amt, input bit tied);
      int c;
      int k;
      bit got;
      bit a;
      model_refund(amt);
      k = exp_q.size();
      chk("ready_idle", bus.refund_ready, 1);
      bus.refund_valid = 1'b1;
      bus.refund_amt   = 16'(amt);
      bus.coin_ack     = tied;
      tick;
      bus.refund_valid = 1'b0;
      c = 1;
      chk("ready_busy", bus.refund_ready, 0);
      got = 1'b0;
      while (!got && c < 3000) begin
         if (bus.done) begin
            chk("short_amt", bus.short_amt, exp_short);
            chk("coins_unpaid", exp_q.size(), 0);
            if (tied) chk("done_cycle", c, 2 * k + 2);
            got = 1'b1;
         end else begin
            a = tied ? 1'b1 : 1'($urandom_range(0, 1));
            if (bus.coin_valid) begin
               if (exp_q.size() == 0) chk("extra_coin", bus.coin_valid, 0);
               else begin
                  chk("coin_out", bus.coin_out, exp_q[0]);
                  if (a) void'(exp_q.pop_front());
               end
            end else begin
               chk("coin_out_idle", bus.coin_out, NONE);
            end
            bus.coin_ack = a;
            tick;
            c++;
         end
      end
      if (!got) chk("done_timeout", got, 1);
      bus.coin_ack = 1'b0;
      tick;
      chk("ready_after_done", bus.refund_ready, 1);
      chk("done_one_cycle", bus.done, 0);
      chk("empty", bus.empty, model_empty());
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 4; i++) inv_m[i] = 0;
      bus.refund_valid = 1'b1;
      bus.refund_amt   = 16'd50;
      bus.coin_ack     = 1'b0;
      bus.load_valid   = 1'b0;
      bus.load_coin    = NONE;
      bus.load_count   = '0;
      rst = 1'b1;
      tick;
      tick;
      chk("rst_ready", bus.refund_ready, 1);
      chk("rst_coin_valid", bus.coin_valid, 0);
      chk("rst_coin_out", bus.coin_out, NONE);
      chk("rst_done", bus.done, 0);
      chk("rst_short", bus.short_amt, 0);
      chk("rst_empty", bus.empty, 4'b1111);
      rst = 1'b0;
      bus.refund_valid = 1'b0;
      tick;
      chk("post_rst_ready", bus.refund_ready, 1);

      // Q2 D1 N3, refund 65 -> Q Q D N, done at N+10
      do_load(2, 2);
      do_load(1, 1);
      do_load(0, 3);
      chk("empty_loaded", bus.empty, 4'b1000);
      run_refund(65, 1'b1);
      chk("quarter_empty", bus.empty[2], 1);

      // Q0 D1 N2, refund 40 -> D N N, short 20
      do_load(1, 1);
      run_refund(40, 1'b1);
      chk("all_empty", bus.empty, 4'b1111);

      // Sub-nickel remainder and zero refund
      do_load(0, 5);
      run_refund(7, 1'b1);
      run_refund(0, 1'b1);

      // Hopper stall with refund_valid pulses while busy
      do_load(3, 1);
      model_refund(100);
      bus.refund_valid = 1'b1;
      bus.refund_amt   = 16'd100;
      bus.coin_ack     = 1'b0;
      tick;
      bus.refund_valid = 1'b0;
      tick;
      for (int j = 0; j < 6; j++) begin
         chk("stall_valid", bus.coin_valid, 1);
         chk("stall_coin", bus.coin_out, DOLLAR);
         chk("stall_ready", bus.refund_ready, 0);
         bus.coin_ack     = (j == 5);
         bus.refund_valid = j[0];
         bus.refund_amt   = 16'd5;
         tick;
      end
      bus.coin_ack     = 1'b0;
      bus.refund_valid = 1'b0;
      chk("stall_select", bus.coin_valid, 0);
      tick;
      chk("stall_done", bus.done, 1);
      chk("stall_short", bus.short_amt, 0);
      tick;
      chk("stall_ready_back", bus.refund_ready, 1);
      tick;
      chk("stall_no_accept", bus.refund_ready, 1);

      // Load DIME 3 in the same cycle the last DIME is acked -> 3 remain
      do_load(1, 1);
      model_refund(10);
      bus.refund_valid = 1'b1;
      bus.refund_amt   = 16'd10;
      tick;
      bus.refund_valid = 1'b0;
      tick;
      chk("sim_coin", bus.coin_out, DIME);
      bus.coin_ack   = 1'b1;
      bus.load_valid = 1'b1;
      bus.load_coin  = DIME;
      bus.load_count = INV_W'(3);
      tick;
      bus.coin_ack   = 1'b0;
      bus.load_valid = 1'b0;
      bus.load_coin  = NONE;
      inv_m[1] = inv_m[1] + 3;
      tick;
      chk("sim_done", bus.done, 1);
      chk("sim_short", bus.short_amt, 0);
      tick;
      run_refund(40, 1'b1);

      // Saturation: 200 + 100 dollars -> 255
      do_load(3, 200);
      do_load(3, 100);
      run_refund(25600, 1'b1);

      // Randomized loads and refunds with random hopper acks
      for (int it = 0; it < 25; it++) begin
         int nl;
         nl = int'($urandom_range(0, 2));
         for (int l = 0; l < nl; l++)
            do_load(int'($urandom_range(0, 3)), int'($urandom_range(0, 20)));
         run_refund(int'($urandom_range(0, 400)), 1'($urandom_range(0, 1)));
      end

      // Reset while a coin is being offered
      do_load(0, 3);
      bus.refund_valid = 1'b1;
      bus.refund_amt   = 16'd20;
      tick;
      bus.refund_valid = 1'b0;
      tick;
      chk("pre_rst_valid", bus.coin_valid, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_async_valid", bus.coin_valid, 0);
      chk("rst_async_coin", bus.coin_out, NONE);
      tick;
      chk("rst_no_done", bus.done, 0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) inv_m[i] = 0;
      for (int j = 0; j < 3; j++) begin
         tick;
         chk("post_rst_no_done", bus.done, 0);
      end
      chk("post_rst_ready2", bus.refund_ready, 1);
      chk("post_rst_empty", bus.empty, 4'b1111);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vm2002_change.md
# vm2002_change

Change-return engine for the vm2002 vending machine: the outbound counterpart of coin acceptance. It takes a refund amount in cents from the vending controller and pays it out one coin at a time to the coin hopper over a valid/ack handshake. Coins are chosen greedily, largest denomination first, from per-denomination inventory counters. Any amount it cannot pay is reported as a shortfall. The supplier refills the inventory through a load port.

## Interface
- INV_W, default 8: width of each per-denomination inventory counter; counters saturate at 2^INV_W-1.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- refund_valid  in  1  refund request present.
- refund_amt  in  16  refund amount in cents; sampled on accept.
- refund_ready  out  1  high only in IDLE; accept = refund_valid & refund_ready.
- coin_valid  out  1  coin_out is offered to the hopper.
- coin_out  out  coin_t  denomination offered; NONE when coin_valid=0.
- coin_ack  in  1  hopper has taken coin_out; ignored when coin_valid=0.
- load_valid  in  1  supplier inventory load.
- load_coin  in  coin_t  denomination to load; NONE is ignored.
- load_count  in  INV_W  coins added.
- done  out  1  one-cycle pulse when a refund completes.
- short_amt  out  16  unpaid cents of the last refund; valid from the done pulse until the next accept.
- empty  out  4  per-denomination inventory == 0; bit order {DOLLAR,QUARTER,DIME,NICKEL}.

## Operation
- FSM states: IDLE, SELECT, ISSUE, DONE.
- IDLE -> SELECT on accept. On accept, remaining <= refund_amt and short_amt <= 0.
- SELECT: pick the largest denomination d with value(d) <= remaining and inv(d) > 0.
  - If d exists: latch coin_out <= d and go to ISSUE.
  - Otherwise: short_amt <= remaining and go to DONE. This covers remaining == 0.
- ISSUE: coin_valid=1; coin_out stays stable until coin_ack.
  - On ack: remaining -= value(d), inv(d) -= 1, go to SELECT.
- DONE: done=1 for one cycle, then IDLE.
- Denomination values: NICKEL 5, DIME 10, QUARTER 25, DOLLAR 100.
- Remainders below 5 cents are never payable and end in short_amt.
- Arithmetic: remaining is 16-bit unsigned. The subtract never underflows, because selection guarantees value <= remaining.
- Load: inv(load_coin) <= min(inv + load_count, 2^INV_W-1).
  - Loads are accepted in any state, including mid-refund.
  - A newly loaded coin is usable at the next SELECT.
- Simultaneous load and ack-decrement on the same denomination: inv <= min(inv + load_count - 1, max).
- Reset values: state IDLE; refund_ready=1 (valid ignored while rst=1); coin_valid=0; coin_out=NONE; done=0; short_amt=0; all inventories 0; empty=4'b1111.
- Reset mid-refund: the request is abandoned immediately. coin_valid drops asynchronously, and no done pulse is produced.

## Timing
- Accept at edge N: SELECT during cycle N+1.
- First coin_valid during cycle N+2.
- Each coin costs 1 SELECT cycle plus at least 1 ISSUE cycle. With coin_ack tied high, a k-coin refund asserts done in cycle N+2k+2.
- Zero-amount refund: done in cycle N+2 with short_amt=0.
- refund_ready falls in cycle N+1 and returns in the cycle after done.
- empty is registered and reflects inventory after the edge that changed it.
- coin_valid, coin_out, done, and short_amt are all registered (no combinational path from inputs).

## Structure
- Shared items in vm2002_pkg:
  - coin_t: NONE, NICKEL, DIME, QUARTER, DOLLAR.
  - Function coin_value(coin_t) returning 16-bit cents.
  - change_state_t enum.
- One natural sub-module: vm2002_coin_inv.
  - One instance per denomination.
  - Saturating counter with inc(load_count)/dec(1) ports and an empty flag.
- The FSM and greedy selector live in vm2002_change.

## Test plan
- Inventory DOLLAR 0, QUARTER 2, DIME 1, NICKEL 3; refund 65, ack tied 1 -> coins QUARTER, QUARTER, DIME, NICKEL; done at N+10; short_amt=0; QUARTER inventory ends at 0.
- Inventory QUARTER 0, DIME 1, NICKEL 2; refund 40 -> DIME, NICKEL, NICKEL; short_amt=20; empty=4'b1111.
- Inventory NICKEL 5; refund 7 -> one NICKEL; short_amt=2. Refund 0 -> no coins; done at N+2; short_amt=0.
- Refund 100 with DOLLAR 1; hold coin_ack low 5 cycles -> coin_valid=1 and coin_out=DOLLAR stable for 6 cycles; refund_valid pulses during this time are not accepted.
- Inventory DIME 1; during ISSUE of that DIME, load DIME count 3 in the same cycle as ack -> DIME inventory=3. Separately, load 200+100 with INV_W=8 -> saturates at 255.
- Assert rst during ISSUE -> coin_valid=0 at once, no done pulse; after release, refund_ready=1 and empty=4'b1111.
